dds_uart_cmd_decoder: RTL

//  Parses the UART byte stream into per-channel DDS settings: signal type, tuning word M, offset, amplitude.

---
 rtl/dds_uart_cmd_decoder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/dds_uart_cmd_decoder.sv
// dds_uart_cmd_decoder
//   Turns the UART RX byte stream into per-channel DDS settings. A frame is a
//   header byte (channel in [7:4], signal type in [3:0]) followed by the M,
//   OFFSET and AMPL fields, each PARAM_BYTES long and sent MSB byte first. An
//   optional XOR checksum byte ends the frame. Field bytes go into shadow
//   registers only. On the final byte the addressed channel's outputs are
//   updated together, one cycle later. Frames that stall longer than
//   TIMEOUT_CYCLES are aborted. Frames that address a missing channel, or that
//   carry a wrong checksum, are dropped.
// Ports
//   sysclk      : system clock
//   reset       : asynchronous active-low reset
//   rx_data     : received byte, qualified by rx_valid
//   rx_valid    : one-cycle strobe from the UART receiver
//   signal_type : 4 bits per channel, channel k at [4k+3:4k]
//   m_word      : tuning word M, PW bits per channel
//   offset      : DC offset, PW bits per channel
//   amplitude   : amplitude, PW bits per channel
//   update      : one-cycle pulse per channel when its outputs changed
//   frame_err   : one-cycle pulse when a frame is dropped
//   err_cause   : with frame_err: 1 timeout, 2 bad channel, 3 checksum
//   busy        : high while a frame is in progress
module dds_uart_cmd_decoder #(
  parameter int NUM_CH         = 2,
  parameter int PARAM_BYTES    = 2,
  parameter int CHECKSUM_EN    = 1,
  parameter int TIMEOUT_CYCLES = 260417
) (
  input  logic                            sysclk,
  input  logic                            reset,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic [4*NUM_CH-1:0]             signal_type,
  output logic [8*PARAM_BYTES*NUM_CH-1:0] m_word,
  output logic [8*PARAM_BYTES*NUM_CH-1:0] offset,
  output logic [8*PARAM_BYTES*NUM_CH-1:0] amplitude,
  output logic [NUM_CH-1:0]               update,
  output logic                            frame_err,
  output logic [1:0]                      err_cause,
  output logic                            busy
);

  localparam int PW    = 8 * PARAM_BYTES;
  localparam int CNT_W = (PARAM_BYTES > 1) ? $clog2(PARAM_BYTES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_M, S_OFF, S_AMP, S_CSUM} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TO_W-1:0]   to_q;
  logic [7:0]        hdr_q;
  logic [7:0]        csum_q;
  logic [PW-1:0]     m_sh_q;
  logic [PW-1:0]     off_sh_q;
  logic [PW-1:0]     amp_sh_q;

  logic [4*NUM_CH-1:0]  type_q;
  logic [PW*NUM_CH-1:0] m_q;
  logic [PW*NUM_CH-1:0] off_q;
  logic [PW*NUM_CH-1:0] amp_q;
  logic [NUM_CH-1:0]    upd_q;
  logic                 ferr_q;
  logic [1:0]           cause_q;

  // Shift a byte into the LSB end of a field; written with a shift so that
  // PARAM_BYTES = 1 needs no special slice.
  function automatic logic [PW-1:0] shift_in(input logic [PW-1:0] v, input logic [7:0] b);
    logic [PW-1:0] t;
    t      = v << 8;
    t[7:0] = b;
    return t;
  endfunction

  logic          last_byte;
  logic          to_exp;
  logic          frame_end;
  logic          bad_ch;
  logic          csum_ok;
  logic [PW-1:0] amp_fin_d;
  logic [PW-1:0] amp_commit_d;

  assign last_byte = (cnt_q == CNT_W'(PARAM_BYTES - 1));
  // A byte arriving in the expiry cycle wins over the timeout.
  assign to_exp    = (state_q != S_IDLE) && !rx_valid && (to_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign amp_fin_d = shift_in(amp_sh_q, rx_data);
  assign frame_end = rx_valid && ((state_q == S_CSUM) ||
                     ((CHECKSUM_EN == 0) && (state_q == S_AMP) && last_byte));
  assign bad_ch    = ({28'd0, hdr_q[7:4]} >= 32'(NUM_CH));
  assign csum_ok   = (CHECKSUM_EN == 0) || (csum_q == rx_data);
  // Without a checksum the last AMPL byte is still in flight at commit time.
  assign amp_commit_d = (CHECKSUM_EN != 0) ? amp_sh_q : amp_fin_d;

  // Frame FSM, byte counter, timeout counter and shadow registers
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      to_q     <= '0;
      hdr_q    <= '0;
      csum_q   <= '0;
      m_sh_q   <= '0;
      off_sh_q <= '0;
      amp_sh_q <= '0;
    end else begin
      if (rx_valid || to_exp || (state_q == S_IDLE)) to_q <= '0;
      else                                           to_q <= to_q + 1'b1;

      if (to_exp) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        hdr_q    <= '0;
        csum_q   <= '0;
        m_sh_q   <= '0;
        off_sh_q <= '0;
        amp_sh_q <= '0;
      end else if (rx_valid) begin
        case (state_q)
          S_IDLE: begin
            hdr_q   <= rx_data;
            csum_q  <= rx_data;
            cnt_q   <= '0;
            state_q <= S_M;
          end
          S_M: begin
            m_sh_q <= shift_in(m_sh_q, rx_data);
            csum_q <= csum_q ^ rx_data;
            if (last_byte) begin
              cnt_q   <= '0;
              state_q <= S_OFF;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_OFF: begin
            off_sh_q <= shift_in(off_sh_q, rx_data);
            csum_q   <= csum_q ^ rx_data;
            if (last_byte) begin
              cnt_q   <= '0;
              state_q <= S_AMP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_AMP: begin
            amp_sh_q <= amp_fin_d;
            csum_q   <= csum_q ^ rx_data;
            if (last_byte) begin
              cnt_q   <= '0;
              state_q <= (CHECKSUM_EN != 0) ? S_CSUM : S_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_CSUM: begin
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Commit / error stage: outputs and pulses register one cycle after the final byte
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      type_q  <= '0;
      m_q     <= '0;
      off_q   <= '0;
      amp_q   <= '0;
      upd_q   <= '0;
      ferr_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      upd_q   <= '0;
      ferr_q  <= 1'b0;
      cause_q <= 2'd0;
      if (to_exp) begin
        ferr_q  <= 1'b1;
        cause_q <= 2'd1;
      end else if (frame_end) begin
        if (bad_ch) begin
          ferr_q  <= 1'b1;
          cause_q <= 2'd2;
        end else if (!csum_ok) begin
          ferr_q  <= 1'b1;
          cause_q <= 2'd3;
        end else begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (hdr_q[7:4] == 4'(k)) begin
              type_q[4*k +: 4]  <= hdr_q[3:0];
              m_q[PW*k +: PW]   <= m_sh_q;
              off_q[PW*k +: PW] <= off_sh_q;
              amp_q[PW*k +: PW] <= amp_commit_d;
              upd_q[k]          <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign signal_type = type_q;
  assign m_word      = m_q;
  assign offset      = off_q;
  assign amplitude   = amp_q;
  assign update      = upd_q;
  assign frame_err   = ferr_q;
  assign err_cause   = cause_q;
  assign busy        = (state_q != S_IDLE);

endmodule
